// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_pkg
// Description : Shared constants and types for the UART receive FIFO block.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_fifo_pkg;

    // 20 MHz core clock / 115200 baud
    localparam int UartCmpVal    = 173;
    localparam int FifoQueueSize = 32;
    localparam int RxFifoDepth   = FifoQueueSize;

    typedef logic [11:0] CsrAddrT;

    localparam CsrAddrT RxFifoCsrAddr = 12'h051;

    // Read-data layout of the RX data/status CSR
    typedef struct packed {
        logic [20:0] pad;
        logic        framing;
        logic        overrun;
        logic        valid;
        logic [7:0]  data;
    } UartRxCsrT;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fsm
// Description : 8N1 receiver front end: input synchroniser, bit timing and
//               deserialiser. Emits one-cycle push / framing-error strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
    import uart_rx_fifo_pkg::*;
#(
    parameter int CMP_VAL = UartCmpVal
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       push_o,
    output logic       frame_err_o
);

    localparam int               CNT_W     = $clog2(CMP_VAL);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CMP_VAL / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CMP_VAL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rx_meta_q;
    logic             rx_s_q;
    uart_rx_state_e   state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             push_q;
    logic             ferr_q;

    // Two-flop synchroniser; idle-high line so flops reset to 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM: start-bit qualification at mid-bit, then centre-sampled data and stop bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q   <= RX_DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            // Line returned high before mid start bit: glitch
                            state_q <= RX_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_s_q) begin
                            push_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign byte_o      = shift_q;
    assign push_o      = push_q;
    assign frame_err_o = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receiver with byte FIFO, sticky error flags, a single
//               read-and-pop CSR and a level interrupt while data is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int      CmpVal    = UartCmpVal,
    parameter int      Depth     = RxFifoDepth,
    parameter CsrAddrT RxCsrAddr = RxFifoCsrAddr
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    input  logic        csr_enable,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_out,
    output logic        rx_irq
);

    localparam int              PTR_W    = $clog2(Depth);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(Depth);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [7:0]       rx_byte;
    logic             rx_push;
    logic             rx_ferr;

    logic [7:0]       mem_q [Depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             framing_q, framing_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             pop_req;
    logic             do_pop;
    logic             do_push;
    UartRxCsrT        csr_s;

    uart_rx_fsm #(
        .CMP_VAL (CmpVal)
    ) u_fsm (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_i        (rx),
        .byte_o      (rx_byte),
        .push_o      (rx_push),
        .frame_err_o (rx_ferr)
    );

    // FIFO bookkeeping; a pop frees the slot the same-cycle push needs when full
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        pop_req    = csr_enable && (csr_addr == RxCsrAddr);
        do_pop     = pop_req && !fifo_empty;
        do_push    = rx_push && (!fifo_full || do_pop);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        framing_d = framing_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Any read clears the sticky flags; a new error in the same cycle wins
        if (pop_req) begin
            overrun_d = 1'b0;
            framing_d = 1'b0;
        end
        if (rx_push && fifo_full && !do_pop) begin
            overrun_d = 1'b1;
        end
        if (rx_ferr) begin
            framing_d = 1'b1;
        end
    end

    // Pointer, count and flag state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            framing_q <= framing_d;
        end
    end

    // Storage array; contents are only observable while count says valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

    // Read data is built straight from current state
    always_comb begin
        csr_s         = '0;
        csr_s.framing = framing_q;
        csr_s.overrun = overrun_q;
        csr_s.valid   = !fifo_empty;
        csr_s.data    = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    end

    assign csr_out = csr_s;
    assign rx_irq  = !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo (bit period 16 clocks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int          BIT_T   = 16;
    localparam logic [11:0] RD_ADDR = 12'h051;

    logic        clk;
    logic        reset_n;
    logic        rx;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [31:0] csr_out;
    logic        rx_irq;

    int n_tests;
    int n_fail;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovr;
    bit         m_frm;

    typedef struct {
        logic [7:0]  data;
        bit          stop_ok;
        logic [31:0] exp_csr;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[6];

    uart_rx_fifo #(
        .CmpVal    (BIT_T),
        .Depth     (32),
        .RxCsrAddr (RD_ADDR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .csr_enable (csr_enable),
        .csr_addr   (csr_addr),
        .csr_out    (csr_out),
        .rx_irq     (rx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_T) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_T) @(negedge clk);
        end
        rx = stop_ok;
        repeat (BIT_T) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic csr_access(input logic [11:0] addr);
        @(negedge clk);
        csr_enable = 1'b1;
        csr_addr   = addr;
        @(posedge clk);
        #1;
        csr_enable = 1'b0;
        csr_addr   = RD_ADDR;
        @(negedge clk);
    endtask

    function automatic logic [31:0] model_csr();
        logic [7:0] h;
        h = (mq.size() != 0) ? mq[0] : 8'h00;
        return {21'b0, m_frm, m_ovr, (mq.size() != 0), h};
    endfunction

    function automatic void model_frame(input logic [7:0] d, input bit stop_ok);
        if (!stop_ok) m_frm = 1'b1;
        else if (mq.size() >= 32) m_ovr = 1'b1;
        else mq.push_back(d);
    endfunction

    task automatic model_read_check(input string name);
        @(negedge clk);
        check({name, "_csr"}, csr_out, model_csr());
        check({name, "_irq"}, {31'b0, rx_irq}, {31'b0, (mq.size() != 0)});
        csr_access(RD_ADDR);
        if (mq.size() != 0) void'(mq.pop_front());
        m_ovr = 1'b0;
        m_frm = 1'b0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        m_ovr      = 1'b0;
        m_frm      = 1'b0;
        reset_n    = 1'b0;
        rx         = 1'b1;
        csr_enable = 1'b0;
        csr_addr   = RD_ADDR;

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_csr", csr_out, 32'h0);
        check("reset_irq", {31'b0, rx_irq}, 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven single frames, each followed by one read
        vecs[0] = '{8'h55, 1'b1, 32'h155, 1'b1};
        vecs[1] = '{8'hA3, 1'b0, 32'h400, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 32'h100, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 32'h1FF, 1'b1};
        vecs[4] = '{8'h80, 1'b0, 32'h400, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 32'h13C, 1'b1};
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].stop_ok);
            check($sformatf("vec%0d_csr", v), csr_out, vecs[v].exp_csr);
            check($sformatf("vec%0d_irq", v), {31'b0, rx_irq}, {31'b0, vecs[v].exp_irq});
            csr_access(RD_ADDR);
            check($sformatf("vec%0d_csr_after_pop", v), csr_out, 32'h0);
            check($sformatf("vec%0d_irq_after_pop", v), {31'b0, rx_irq}, 32'h0);
        end

        // Access to another CSR address must not pop
        send_frame(8'h5A, 1'b1);
        csr_access(12'h050);
        check("wrong_addr_no_pop", csr_out, 32'h15A);
        csr_access(RD_ADDR);
        check("wrong_addr_then_pop", csr_out, 32'h0);

        // Short low glitch is rejected
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_csr", csr_out, 32'h0);
        check("glitch_irq", {31'b0, rx_irq}, 32'h0);

        // 33 frames with no reads: last one overruns
        for (int i = 0; i < 33; i++) send_frame(8'(i), 1'b1);
        check("overrun_csr", csr_out, 32'h300);
        check("overrun_irq", {31'b0, rx_irq}, 32'h1);
        csr_access(RD_ADDR);
        for (int i = 1; i < 32; i++) begin
            check($sformatf("drain_%0d", i), csr_out, 32'h100 | 32'(i));
            csr_access(RD_ADDR);
        end
        check("drain_empty", csr_out, 32'h0);

        // Full FIFO: push of 0x7E lands on the same edge as a pop
        for (int i = 0; i < 32; i++) send_frame(8'(i), 1'b1);
        check("full_csr", csr_out, 32'h100);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                bit seen;
                seen = 1'b0;
                for (int n = 0; n < 400 && !seen; n++) begin
                    @(negedge clk);
                    if (dut.u_fsm.push_o) seen = 1'b1;
                end
                if (!seen) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL coincide_wait: got no push strobe, expected one within 400 cycles");
                end else begin
                    csr_enable = 1'b1;
                    @(posedge clk);
                    #1;
                    csr_enable = 1'b0;
                end
            end
        join
        @(negedge clk);
        check("coincide_csr", csr_out, 32'h101);
        for (int i = 1; i < 32; i++) begin
            check($sformatf("coincide_drain_%0d", i), csr_out, 32'h100 | 32'(i));
            csr_access(RD_ADDR);
        end
        check("coincide_last", csr_out, 32'h17E);
        csr_access(RD_ADDR);
        check("coincide_empty", csr_out, 32'h0);

        // Reset during DATA of 0xFF abandons the frame
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_T) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_T) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_reset_csr", csr_out, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("after_reset_csr", csr_out, 32'h0);
        send_frame(8'h12, 1'b1);
        check("after_reset_frame", csr_out, 32'h112);
        csr_access(RD_ADDR);
        check("after_reset_empty", csr_out, 32'h0);

        // Randomised frames and reads against the queue model
        mq.delete();
        m_ovr = 1'b0;
        m_frm = 1'b0;
        for (int k = 0; k < 50; k++) begin
            logic [7:0] d;
            bit         ok;
            d  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send_frame(d, ok);
            model_frame(d, ok);
            if ($urandom_range(0, 3) == 0) model_read_check($sformatf("rand%0d", k));
        end
        for (int k = 0; k < 40 && mq.size() != 0; k++) model_read_check($sformatf("rdrain%0d", k));
        model_read_check("rand_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 UART receiver for the core's serial input; the receive counterpart of the existing CSR-mapped UART transmit FIFO.
- Synchronises `rx`, times bits from the core clock with a fixed compare value, and pushes each good byte into a FIFO.
- Software drains the FIFO through a single read-and-pop CSR.
- A level interrupt is raised while data is pending.

Parameters:
- CmpVal, UartCmpVal (20 MHz / 115200 = 173), clock cycles per bit.
- Depth, FifoQueueSize (32), FIFO entries, power of two.
- RxCsrAddr, 'h51, CSR address of the RX data/status register.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- rx  in  1  serial line, idle high, asynchronous to clk
- csr_enable  in  1  CSR access strobe from the decode stage
- csr_addr  in  12  CSR address (CsrAddrT)
- csr_out  out  32  read data: [7:0] head byte, [8] valid, [9] overrun, [10] framing error, [31:11] zero
- rx_irq  out  1  high while the FIFO is non-empty

Behaviour:
- Reset (async, reset_n=0):
  - FSM = IDLE; counters, pointers and flags cleared.
  - Synchroniser flops reset to 1.
  - csr_out = 0 and rx_irq = 0.
- Reset asserted mid-frame abandons the frame; no partial push.
- Input sync:
  - rx passes through 2 flops before use, giving 2 cycles of latency.
  - All sampling uses the synchronised value rx_s.
- Bit counter: width $clog2(CmpVal); cleared on every state change.
- FSM:
  - IDLE: rx_s==0 → START.
  - START: at cnt==CmpVal/2-1 (mid start bit), rx_s==0 → DATA with bit index 0; rx_s==1 → IDLE (glitch rejected).
  - DATA: at cnt==CmpVal-1, shift rx_s into bit 7 of the shift register (LSB first, shift right) and increment the bit index. After bit index 7 → STOP.
  - STOP: at cnt==CmpVal-1 (mid stop bit), rx_s==1 → push byte; rx_s==0 → set framing flag, no push. Both cases → IDLE.
  - Re-entering IDLE mid stop bit is intended; the next falling edge is detected normally.
- FIFO:
  - Depth entries × 8 bits, with read/write pointers plus a count.
  - Push while full (and no pop in the same cycle): byte dropped, overrun flag set.
  - Pop: occurs when csr_enable && csr_addr==RxCsrAddr.
    - Head advances at the clock edge.
    - Overrun and framing flags clear at the same edge.
    - A pop when empty is ignored.
  - Simultaneous push and pop: both happen and count is unchanged. This holds when full too: the push is accepted and no overrun is flagged.
  - Pointers wrap modulo Depth.
- csr_out:
  - Combinational from current state: {21'b0, framing, overrun, !empty, head byte}.
  - Head byte reads 0 when empty.
  - A push and its visibility on csr_out are separated by 1 cycle (registered FIFO write).
- rx_irq = !empty, registered with the FIFO state (no extra delay beyond the push edge).
- Sticky flags stay set until a pop; a pop on an empty FIFO still clears them.

Decomposition:
- Add to config_pkg: RxFifoCsrAddr = 'h51 and RxFifoDepth = FifoQueueSize. UartCmpVal already exists there.
- Add to config_pkg: a packed struct UartRxCsrT {pad[20:0], framing, overrun, valid, data[7:0]}.
- Sub-module: uart_rx_fsm (synchroniser, bit timing, deserialiser). Outputs are byte, push strobe and framing strobe; the FIFO and CSR logic stay in the top.

Test Plan (bench uses CmpVal=16 for speed):
- Frame 0x55, good stop bit, then CSR read → before read csr_out = 'h155 and rx_irq=1; after the pop edge csr_out=0 and rx_irq=0.
- rx low pulse for 4 cycles (< CmpVal/2) → FSM returns to IDLE, no push, csr_out stays 0.
- Frame 0xA3 with stop bit 0 → no push; csr_out = 'h400. One read clears it to 0.
- 33 frames 0x00..0x20, no reads → csr_out = 'h300 (valid, overrun, byte 0x00). Successive reads return 0x01..0x1F with overrun cleared after the first read.
- FIFO full; the stop-bit push of 0x7E coincides with a CSR pop → count stays 32, overrun=0, and 0x7E is read last.
- reset_n pulled low during DATA of frame 0xFF, released, then frame 0x12 sent → only 'h112 is ever read.
